load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | load_store_unit                                                             |
// | Single-outstanding data-memory load/store sequencer with alignment checks.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           alu_op,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // alu_op = {funct7[5:0], funct3, opcode}
  localparam logic [15:0] OP_LB  = 16'h0003;
  localparam logic [15:0] OP_LH  = 16'h0083;
  localparam logic [15:0] OP_LW  = 16'h0103;
  localparam logic [15:0] OP_LBU = 16'h0203;
  localparam logic [15:0] OP_LHU = 16'h0283;
  localparam logic [15:0] OP_SB  = 16'h0023;
  localparam logic [15:0] OP_SH  = 16'h00A3;
  localparam logic [15:0] OP_SW  = 16'h0123;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t                  state_q, state_d;
  logic                    store_q, store_d;
  logic                    uns_q, uns_d;
  logic                    mis_q, mis_d;
  logic [1:0]              size_q, size_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    dec_valid;
  logic                    dec_store;
  logic                    dec_uns;
  logic [1:0]              dec_size;
  logic                    dec_mis;
  logic [DATA_WIDTH-1:0]   lane_w;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   store_data;
  logic [3:0]              store_strb;

  always_comb begin
    dec_valid = 1'b1;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_size  = SZ_WORD;
    case (alu_op)
      OP_LB:   dec_size = SZ_BYTE;
      OP_LH:   dec_size = SZ_HALF;
      OP_LW:   dec_size = SZ_WORD;
      OP_LBU:  begin dec_size = SZ_BYTE; dec_uns = 1'b1; end
      OP_LHU:  begin dec_size = SZ_HALF; dec_uns = 1'b1; end
      OP_SB:   begin dec_size = SZ_BYTE; dec_store = 1'b1; end
      OP_SH:   begin dec_size = SZ_HALF; dec_store = 1'b1; end
      OP_SW:   begin dec_size = SZ_WORD; dec_store = 1'b1; end
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    dec_mis = 1'b0;
    if (dec_size == SZ_HALF) begin
      dec_mis = addr[0];
    end else if (dec_size == SZ_WORD) begin
      dec_mis = (addr[1:0] != 2'b00);
    end
  end

  // Move the addressed lane down to bit 0, then extend to full width.
  assign lane_w = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'h0, lane_w[7:0]}
                                : {{24{lane_w[7]}}, lane_w[7:0]};
      SZ_HALF: load_val = uns_q ? {16'h0, lane_w[15:0]}
                                : {{16{lane_w[15]}}, lane_w[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    store_data = wdata_q;
    store_strb = 4'b1111;
    case (size_q)
      SZ_BYTE: begin
        store_data = {4{wdata_q[7:0]}};
        store_strb = 4'b0001 << addr_q[1:0];
      end
      SZ_HALF: begin
        store_data = {2{wdata_q[15:0]}};
        store_strb = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = wdata_q;
        store_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    uns_d      = uns_q;
    mis_d      = mis_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    ready      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = 4'b0000;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start && dec_valid) begin
          store_d = dec_store;
          uns_d   = dec_uns;
          size_d  = dec_size;
          mis_d   = dec_mis;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = dec_mis ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_we   = store_q;
        mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
        if (store_q) begin
          mem_wdata = store_data;
          mem_wstrb = store_strb;
        end
        if (mem_ack) begin
          if (!store_q) begin
            rd_data_d = load_val;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        misaligned = mis_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      store_q   <= 1'b0;
      uns_q     <= 1'b0;
      mis_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      uns_q     <= uns_d;
      mis_q     <= mis_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_load_store_unit                                                          |
// | Scoreboard bench: directed scenarios then randomized loads/stores.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_load_store_unit;

  localparam logic [15:0] C_LB  = 16'h0003;
  localparam logic [15:0] C_LH  = 16'h0083;
  localparam logic [15:0] C_LW  = 16'h0103;
  localparam logic [15:0] C_LBU = 16'h0203;
  localparam logic [15:0] C_LHU = 16'h0283;
  localparam logic [15:0] C_SB  = 16'h0023;
  localparam logic [15:0] C_SH  = 16'h00A3;
  localparam logic [15:0] C_SW  = 16'h0123;
  localparam logic [15:0] C_ADD = 16'h0033;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] alu_op;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_ack;
  logic        ready, done, misaligned, mem_req, mem_we;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .rd_data(rd_data),
    .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        mis;
    logic [31:0] rd;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  done_t       done_q[$];
  req_t        req_q[$];
  logic [31:0] rd_model = 32'h0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Reference decode: size in bytes, store flag, signedness.
  function automatic void decode(input logic [15:0] op, output bit valid, output bit st,
                                 output int sz, output bit sg);
    valid = 1; st = 0; sz = 4; sg = 0;
    case (op)
      C_LB:  begin sz = 1; sg = 1; end
      C_LH:  begin sz = 2; sg = 1; end
      C_LW:  sz = 4;
      C_LBU: sz = 1;
      C_LHU: sz = 2;
      C_SB:  begin sz = 1; st = 1; end
      C_SH:  begin sz = 2; st = 1; end
      C_SW:  begin sz = 4; st = 1; end
      default: valid = 0;
    endcase
  endfunction

  function automatic logic [31:0] load_ref(input logic [31:0] rdat, input logic [31:0] a,
                                           input int sz, input bit sg);
    logic [31:0] v;
    v = rdat >> (8 * (a % 4));
    if (sz == 1) return (sg && v[7])  ? (32'hFFFFFF00 | {24'h0, v[7:0]})  : {24'h0, v[7:0]};
    if (sz == 2) return (sg && v[15]) ? (32'hFFFF0000 | {16'h0, v[15:0]}) : {16'h0, v[15:0]};
    return rdat;
  endfunction

  // Monitor: compares every DUT-presented request/completion against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        chk("idle_done", {31'h0, done}, 32'h0);
        chk("idle_mem_req", {31'h0, mem_req}, 32'h0);
        chk("idle_misaligned", {31'h0, misaligned}, 32'h0);
      end
      if (mem_req) begin
        if (req_q.size() == 0) begin
          fail("spurious_mem_req");
        end else begin
          chk("mem_addr", mem_addr, req_q[0].addr);
          chk("mem_we", {31'h0, mem_we}, {31'h0, req_q[0].we});
          if (req_q[0].we) begin
            chk("mem_wdata", mem_wdata, req_q[0].wdata);
            chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, req_q[0].wstrb});
          end
          if (mem_ack) void'(req_q.pop_front());
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          fail("spurious_done");
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
          chk("rd_data", rd_data, e.rd);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Issues one request; the caller is positioned just after a rising edge.
  task automatic issue(input logic [15:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int waitn, input bit dup);
    bit    valid, st, sg, mis;
    int    sz, t;
    done_t e;
    req_t  r;
    decode(op, valid, st, sz, sg);
    mis = valid && ((a % sz) != 0);
    if (valid) begin
      if (!mis && !st) rd_model = load_ref(rdat, a, sz, sg);
      e.mis = mis;
      e.rd  = rd_model;
      e.cyc = cyc + 1 + (mis ? 0 : 1 + waitn);
      done_q.push_back(e);
      if (!mis) begin
        r.addr  = {a[31:2], 2'b00};
        r.we    = st;
        r.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        r.wstrb = 4'(((1 << sz) - 1) << (a % 4));
        req_q.push_back(r);
      end
    end
    start = 1'b1; alu_op = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; alu_op = 16'($urandom); addr = $urandom; wdata = $urandom;
    if (valid && !mis) begin
      for (int i = 0; i < waitn; i++) begin
        if (dup && i == 0) begin start = 1'b1; alu_op = C_LW; addr = 32'h0; end
        @(posedge clk); #1;
        start = 1'b0;
      end
      mem_ack = 1'b1; mem_rdata = rdat;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    t = 0;
    while (!ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!ready) fail("timeout_ready");
    // Idle gap with a stray ack that must be ignored.
    mem_ack = 1'($urandom);
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ops[8];
    logic [15:0] op;
    req_t        r;
    ops = '{C_LB, C_LH, C_LW, C_LBU, C_LHU, C_SB, C_SH, C_SW};
    reset = 1'b1; start = 1'b0; alu_op = 16'h0; addr = 32'h0; wdata = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(C_LB, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
    chk("lb_rd_data", rd_data, 32'hFFFF_FF80);
    issue(C_LHU, 32'h2002, 32'h0, 32'h9234_5678, 3, 0);
    chk("lhu_rd_data", rd_data, 32'h0000_9234);
    issue(C_SB, 32'h11, 32'hAABB_CCDD, 32'h0, 0, 0);
    chk("sb_rd_kept", rd_data, 32'h0000_9234);
    issue(C_LW, 32'h6, 32'h0, 32'h1234_5678, 0, 0);
    issue(C_ADD, 32'h100, 32'h0, 32'h0, 0, 0);
    issue(C_LW, 32'h100, 32'h0, 32'hCAFE_F00D, 2, 1);

    // Reset while a store waits for its ack.
    r.addr = 32'h40; r.we = 1'b1; r.wdata = 32'h5555_AAAA; r.wstrb = 4'hF;
    req_q.push_back(r);
    start = 1'b1; alu_op = C_SW; addr = 32'h40; wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rstreq_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rstreq_ready", {31'h0, ready}, 32'h1);
    chk("rstreq_rd_data", rd_data, 32'h0);
    req_q.delete();
    rd_model = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      int k;
      k  = $urandom_range(0, 9);
      op = (k < 8) ? ops[k] : ((k == 8) ? C_ADD : 16'($urandom));
      issue(op, $urandom, $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    if (done_q.size() != 0) fail("pending_done");
    if (req_q.size() != 0) fail("pending_req");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
